// File: rtl/serial_cmp_ctrl_if.sv
// Handshake and operand/result bundle for serial_cmp_ctrl.
// Host drives start/abort/a/b; the sequencer returns status and flags.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [IDX_W-1:0] mismatch_idx;

  modport master (
    output start, abort, a, b,
    input  busy, done, eq, gt, lt, mismatch_idx
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, eq, gt, lt, mismatch_idx
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial word compare through one 1-bit XNOR cell.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish on the first mismatching bit.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  serial_cmp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_acc;
  logic             found;
  logic             gt_acc;
  logic             lt_acc;

  logic             bit_eq;
  logic             hit;
  logic             found_n;
  logic             gt_n;
  logic             lt_n;
  logic             fin;
  logic [IDX_W-1:0] idx_n;

  // Only the first differing bit decides the ordering.
  always_comb begin
    bit_eq  = ~(sa[WIDTH-1] ^ sb[WIDTH-1]);
    hit     = ~found & ~bit_eq;
    found_n = found | hit;
    gt_n    = hit ? sa[WIDTH-1] : gt_acc;
    lt_n    = hit ? sb[WIDTH-1] : lt_acc;
    idx_n   = hit ? cnt : idx_acc;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    fin     = (cnt == '0) | hit;
`else
    fin     = (cnt == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sa               <= '0;
      sb               <= '0;
      cnt              <= '0;
      idx_acc          <= '0;
      found            <= 1'b0;
      gt_acc           <= 1'b0;
      lt_acc           <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.eq           <= 1'b0;
      bus.gt           <= 1'b0;
      bus.lt           <= 1'b0;
      bus.mismatch_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.b;
            cnt      <= IDX_W'(WIDTH - 1);
            found    <= 1'b0;
            gt_acc   <= 1'b0;
            lt_acc   <= 1'b0;
            idx_acc  <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            sa      <= sa << 1;
            sb      <= sb << 1;
            cnt     <= cnt - 1'b1;
            found   <= found_n;
            gt_acc  <= gt_n;
            lt_acc  <= lt_n;
            idx_acc <= idx_n;
            if (fin) begin
              bus.done         <= 1'b1;
              bus.eq           <= ~found_n;
              bus.gt           <= gt_n;
              bus.lt           <= lt_n;
              bus.mismatch_idx <= idx_n;
              state            <= DONE;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
